// File: rtl/uart_rx_ex3.sv
// 8N1 serial receiver feeding the ex3 CPU input register (INPR) and input flag (FGI).
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop, plus par_err.
module uart_rx_ex3 #(
  parameter int unsigned CLK_DIV   = 234,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 fgi_clr,
  output logic [DATA_BITS-1:0] inpr,
  output logic                 fgi,
  output logic                 ovr,
  output logic                 frm_err,
`ifdef UART_RX_PARITY_EN
  output logic                 par_err,
`endif
  output logic                 rx_busy
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CntHalf = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CntFull = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] inpr_q, inpr_d;
  logic                 fgi_q, fgi_d, ovr_q, ovr_d, frm_err_q, frm_err_d;
  logic                 par_bad_q, par_bad_d, par_err_q, par_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      inpr_q     <= '0;
      fgi_q      <= 1'b0;
      ovr_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      inpr_q     <= inpr_d;
      fgi_q      <= fgi_d;
      ovr_q      <= ovr_d;
      frm_err_q  <= frm_err_d;
      par_bad_q  <= par_bad_d;
      par_err_q  <= par_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    inpr_d    = inpr_q;
    fgi_d     = fgi_q;
    ovr_d     = ovr_q;
    frm_err_d = frm_err_q;
    par_bad_d = par_bad_q;
    par_err_d = par_err_q;
    // Clear first so a byte completing in the same cycle overrides it.
    if (fgi_clr) begin
      fgi_d     = 1'b0;
      ovr_d     = 1'b0;
      par_err_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs_q) begin
          cnt_d   = CntHalf;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = CntFull;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = CntFull;
          if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      StParity: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          par_bad_d = (^shift_q) ^ rxs_q;
          cnt_d     = CntFull;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs_q) begin
          inpr_d    = shift_q;
          fgi_d     = 1'b1;
          ovr_d     = ovr_d | (fgi_q & ~fgi_clr);
          frm_err_d = 1'b0;
          par_err_d = par_bad_q;
          state_d   = StIdle;
        end else begin
          frm_err_d = 1'b1;
          state_d   = StBreak;
        end
      end
      StBreak: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign inpr    = inpr_q;
  assign fgi     = fgi_q;
  assign ovr     = ovr_q;
  assign frm_err = frm_err_q;
  assign rx_busy = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign par_err = par_err_q;
`else
  logic unused_par;
  assign unused_par = par_bad_q ^ par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ex3.sv
// Randomised bench for uart_rx_ex3 against a frame-level reference model.
// Honours UART_RX_PARITY_EN when defined for both bench and design.
module tb_uart_rx_ex3;

  localparam int unsigned ClkDiv = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       fgi_clr;
  logic [7:0] inpr;
  logic       fgi, ovr, frm_err, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: state visible after each whole frame.
  logic [7:0] m_inpr;
  logic       m_fgi, m_ovr, m_frm, m_par;

  uart_rx_ex3 #(.CLK_DIV(ClkDiv), .DATA_BITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .rxd     (rxd),
    .fgi_clr (fgi_clr),
    .inpr    (inpr),
    .fgi     (fgi),
    .ovr     (ovr),
    .frm_err (frm_err),
`ifdef UART_RX_PARITY_EN
    .par_err (par_err),
`endif
    .rx_busy (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".inpr"}, {24'd0, inpr}, {24'd0, m_inpr});
    check({tag, ".fgi"}, {31'd0, fgi}, {31'd0, m_fgi});
    check({tag, ".ovr"}, {31'd0, ovr}, {31'd0, m_ovr});
    check({tag, ".frm"}, {31'd0, frm_err}, {31'd0, m_frm});
`ifdef UART_RX_PARITY_EN
    check({tag, ".par"}, {31'd0, par_err}, {31'd0, m_par});
`endif
  endtask

  task automatic model_reset();
    m_inpr = 8'h00; m_fgi = 1'b0; m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
  endtask

  task automatic pulse_clr();
    fgi_clr = 1'b1;
    tick(1);
    fgi_clr = 1'b0;
    m_fgi = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
  endtask

  // Drives one frame; a low stop bit leaves the line low on return.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pbit);
    rxd = 1'b0;
    tick(ClkDiv);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(ClkDiv);
    end
`ifdef UART_RX_PARITY_EN
    rxd = pbit;
    tick(ClkDiv);
`endif
    rxd = stop;
    tick(ClkDiv);
    tick(4);
    if (stop) begin
      if (m_fgi) m_ovr = 1'b1;
      m_inpr = b;
      m_fgi  = 1'b1;
      m_frm  = 1'b0;
      m_par  = (^b) ^ pbit;
    end else begin
      m_frm = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       p;
    reset = 1'b1; rxd = 1'b1; fgi_clr = 1'b0;
    model_reset();
    tick(3);
    check_model("reset");
    check("reset.busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    tick(5);

    // Plain byte, then consume and receive another.
    send_frame(8'hA5, 1'b1, 1'b0);
    check_model("a5");
    check("a5.busy", {31'd0, rx_busy}, 32'd0);
    pulse_clr();
    check("clr.fgi", {31'd0, fgi}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_model("3c");

    // Overrun: two bytes without consuming.
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check_model("ovr");
    check("ovr.set", {31'd0, ovr}, 32'd1);
    pulse_clr();
    check_model("ovr.clr");

    // Short low glitch is a false start.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(2);
    check("glitch.busy_mid", {31'd0, rx_busy}, 32'd1);
    tick(20);
    check("glitch.busy_end", {31'd0, rx_busy}, 32'd0);
    check_model("glitch");

    // Framing error followed by a held-low break, then a good frame.
    send_frame(8'h55, 1'b0, 1'b0);
    tick(3 * ClkDiv);
    check_model("brk");
    check("brk.busy", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    tick(ClkDiv);
    check("brk.idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0);
    check_model("0f");

    // Reset in the middle of a frame drops the partial byte.
    rxd = 1'b0;
    tick(ClkDiv);
    for (int i = 0; i < 4; i++) begin
      rxd = (i >= 4);
      tick(ClkDiv);
    end
    reset = 1'b1;
    #1;
    model_reset();
    check_model("midrst");
    check("midrst.busy", {31'd0, rx_busy}, 32'd0);
    rxd = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    send_frame(8'h81, 1'b1, 1'b0);
    check_model("81");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    check("par.bad", {31'd0, par_err}, 32'd1);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par.good", {31'd0, par_err}, 32'd0);
`endif

    // Random frames with random consumption between them.
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~(^b) : (^b);
      if ($urandom_range(0, 1) == 1) pulse_clr();
      tick($urandom_range(1, 10));
      send_frame(b, 1'b1, p);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
